// File: rtl/scan_pkg.sv
// Shared constants for the scan-chain tile: bus width, strobe bundle indices and synchronizer depth.
// SCAN_WRAPPER_INPUT_SYNC_EN selects a two-flop input synchronizer; otherwise a single register stage.
package scan_pkg;

    localparam int NUM_IOS_DEFAULT = 8;

    // Strobe bundle bit positions, shared by the tile and its synchronizer.
    localparam int STROBE_W  = 4;
    localparam int IDX_CLK   = 0;
    localparam int IDX_DATA  = 1;
    localparam int IDX_SEL   = 2;
    localparam int IDX_LATCH = 3;

`ifdef SCAN_WRAPPER_INPUT_SYNC_EN
    localparam int SYNC_DEPTH = 2;
`else
    localparam int SYNC_DEPTH = 1;
`endif

endpackage

// File: rtl/scan_sync_edge.sv
// DEPTH-stage synchronizer plus one delay flop per bit on a strobe bundle, with rise/fall flags.
// DEPTH follows SCAN_WRAPPER_INPUT_SYNC_EN through scan_pkg unless overridden.
module scan_sync_edge
    import scan_pkg::*;
#(
    parameter int W     = STROBE_W,
    parameter int DEPTH = SYNC_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_level,
    output logic [W-1:0] o_level_d,
    output logic [W-1:0] o_rise,
    output logic [W-1:0] o_fall
);

    logic [DEPTH-1:0][W-1:0] r_stage;
    logic [W-1:0]            r_level_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stage   <= '0;
            r_level_d <= '0;
        end else begin
            r_stage[0] <= i_async;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
            r_level_d <= r_stage[DEPTH-1];
        end
    end

    assign o_level   = r_stage[DEPTH-1];
    assign o_level_d = r_level_d;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_edge
            assign o_rise[gi] =  r_stage[DEPTH-1][gi] & ~r_level_d[gi];
            assign o_fall[gi] = ~r_stage[DEPTH-1][gi] &  r_level_d[gi];
        end
    endgenerate

endmodule

// File: rtl/scan_wrapper_cell.sv
// One scan-chain tile: oversampled shift/capture/latch of a tiny design's I/O, strobes retimed downstream.
// Build option SCAN_WRAPPER_INPUT_SYNC_EN adds a second synchronizer flop on every strobe input.
module scan_wrapper_cell
    import scan_pkg::*;
#(
    parameter int NUM_IOS = NUM_IOS_DEFAULT,
    parameter int PL      = NUM_IOS - 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               scan_clk_in,
    input  logic               scan_data_in,
    input  logic               scan_select_in,
    input  logic               scan_latch_en_in,
    output logic               scan_clk_out,
    output logic               scan_data_out,
    output logic               scan_select_out,
    output logic               scan_latch_en_out,
    output logic [NUM_IOS-1:0] module_data_in,
    input  logic [NUM_IOS-1:0] module_data_out
);

    logic [STROBE_W-1:0] w_strobe_in;
    logic [STROBE_W-1:0] w_level;
    logic [STROBE_W-1:0] w_level_d;
    logic [STROBE_W-1:0] w_rise;
    logic [STROBE_W-1:0] w_fall;

    assign w_strobe_in[IDX_CLK]   = scan_clk_in;
    assign w_strobe_in[IDX_DATA]  = scan_data_in;
    assign w_strobe_in[IDX_SEL]   = scan_select_in;
    assign w_strobe_in[IDX_LATCH] = scan_latch_en_in;

    scan_sync_edge #(
        .W     (STROBE_W),
        .DEPTH (SYNC_DEPTH)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .i_async   (w_strobe_in),
        .o_level   (w_level),
        .o_level_d (w_level_d),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    logic [PL:0] r_sh;
    logic [PL:0] w_sh_next;
    logic        r_dout;
    logic [PL:0] r_module_data_in;

    always_comb begin
        w_sh_next = r_sh;
        if (w_rise[IDX_CLK]) begin
            if (w_level[IDX_SEL]) begin
                w_sh_next = module_data_out;
            end else begin
                w_sh_next = {r_sh[PL-1:0], w_level[IDX_DATA]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh <= '0;
        end else begin
            r_sh <= w_sh_next;
        end
    end

    // Launching on the synced fall keeps downstream data stable across the whole forwarded high phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout <= 1'b0;
        end else if (w_fall[IDX_CLK]) begin
            r_dout <= r_sh[PL];
        end
    end

    // Reads r_sh, not w_sh_next, so a coincident scan clock rise does not leak into the latched byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_module_data_in <= '0;
        end else if (w_rise[IDX_LATCH]) begin
            r_module_data_in <= r_sh;
        end
    end

    assign scan_clk_out      = w_level_d[IDX_CLK];
    assign scan_select_out   = w_level_d[IDX_SEL];
    assign scan_latch_en_out = w_level_d[IDX_LATCH];
    assign scan_data_out     = r_dout;
    assign module_data_in    = r_module_data_in;

    logic w_unused;
    assign w_unused = ^{w_level[IDX_CLK], w_level[IDX_LATCH], w_level_d[IDX_DATA],
                        w_rise[IDX_DATA], w_rise[IDX_SEL],
                        w_fall[IDX_DATA], w_fall[IDX_SEL], w_fall[IDX_LATCH]};

endmodule

// File: tb/tb_scan_wrapper_cell.sv
// Two daisy-chained tiles driven by a synchronous scan driver, checked against a byte-level chain model.
// Latency expectations follow SCAN_WRAPPER_INPUT_SYNC_EN.
module tb_scan_wrapper_cell;

`ifdef SCAN_WRAPPER_INPUT_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic scan_clk_in = 1'b0, scan_data_in = 1'b0, scan_select_in = 1'b0, scan_latch_en_in = 1'b0;

    logic       t0_clk_out, t0_data_out, t0_sel_out, t0_le_out;
    logic [7:0] t0_mdi;
    logic [7:0] t0_mdo = 8'h00;
    logic       t1_clk_out, t1_data_out, t1_sel_out, t1_le_out;
    logic [7:0] t1_mdi;
    logic [7:0] t1_mdo = 8'h00;

    always #5 clk = ~clk;

    scan_wrapper_cell u_t0 (
        .clk               (clk),
        .reset             (reset),
        .scan_clk_in       (scan_clk_in),
        .scan_data_in      (scan_data_in),
        .scan_select_in    (scan_select_in),
        .scan_latch_en_in  (scan_latch_en_in),
        .scan_clk_out      (t0_clk_out),
        .scan_data_out     (t0_data_out),
        .scan_select_out   (t0_sel_out),
        .scan_latch_en_out (t0_le_out),
        .module_data_in    (t0_mdi),
        .module_data_out   (t0_mdo)
    );

    scan_wrapper_cell u_t1 (
        .clk               (clk),
        .reset             (reset),
        .scan_clk_in       (t0_clk_out),
        .scan_data_in      (t0_data_out),
        .scan_select_in    (t0_sel_out),
        .scan_latch_en_in  (t0_le_out),
        .scan_clk_out      (t1_clk_out),
        .scan_data_out     (t1_data_out),
        .scan_select_out   (t1_sel_out),
        .scan_latch_en_out (t1_le_out),
        .module_data_in    (t1_mdi),
        .module_data_out   (t1_mdo)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: each tile's shift register and latched byte, plus the bit each tile emits per scan clock.
    logic [7:0] m0 = 8'h00, m1 = 8'h00, mdi0 = 8'h00, mdi1 = 8'h00;
    bit   exp0[$], exp1[$];
    logic obs0[$], obs1[$];
    logic prev_ck0 = 1'b0, prev_do0 = 1'b0, prev_ck1 = 1'b0, prev_do1 = 1'b0;

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (t0_data_out !== prev_do0) chk(t0_clk_out, 0, "t0_data_change_clk_low");
        if (t1_data_out !== prev_do1) chk(t1_clk_out, 0, "t1_data_change_clk_low");
        if (prev_ck0 === 1'b1 && t0_clk_out === 1'b0) obs0.push_back(t0_data_out);
        if (prev_ck1 === 1'b1 && t1_clk_out === 1'b0) obs1.push_back(t1_data_out);
        prev_ck0 = t0_clk_out;
        prev_do0 = t0_data_out;
        prev_ck1 = t1_clk_out;
        prev_do1 = t1_data_out;
    endtask

    task automatic idle();
        repeat (S + 4) tick();
    endtask

    // One scan clock seen by the whole chain: tile1 shifts in what tile0 emitted on the previous fall.
    task automatic model_clock(input logic d, input logic sel);
        logic [7:0] n0, n1;
        if (sel) begin
            n0 = t0_mdo;
            n1 = t1_mdo;
        end else begin
            n0 = {m0[6:0], d};
            n1 = {m1[6:0], m0[7]};
        end
        m0 = n0;
        m1 = n1;
        exp0.push_back(m0[7]);
        exp1.push_back(m1[7]);
    endtask

    task automatic scan_clock(input logic d, input logic sel, input int lo, input int hi);
        scan_data_in   = d;
        scan_select_in = sel;
        scan_clk_in    = 1'b0;
        repeat (lo) tick();
        scan_clk_in = 1'b1;
        model_clock(d, sel);
        repeat (hi) tick();
        scan_clk_in = 1'b0;
    endtask

    task automatic shift_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) scan_clock(b[i], 1'b0, 1, 1);
    endtask

    task automatic latch_pulse(input bit check_lat);
        logic [7:0] old0;
        old0 = mdi0;
        scan_latch_en_in = 1'b1;
        mdi0 = m0;
        mdi1 = m1;
        for (int k = 1; k <= S + 1; k++) begin
            tick();
            if (check_lat && k == S) begin
                chk(t0_le_out, 0, "le_out_before_latency");
                chk(t0_mdi, old0, "mdi_before_latency");
            end
            if (check_lat && k == S + 1) begin
                chk(t0_le_out, 1, "le_out_at_latency");
                chk(t0_mdi, mdi0, "mdi_at_latency");
            end
        end
        scan_latch_en_in = 1'b0;
        for (int k = 1; k <= S + 1; k++) begin
            tick();
            if (check_lat && k == S) chk(t0_le_out, 1, "le_out_width");
            if (check_lat && k == S + 1) chk(t0_le_out, 0, "le_out_fall");
        end
        idle();
        chk(t0_mdi, mdi0, "t0_mdi_latched");
        chk(t1_mdi, mdi1, "t1_mdi_latched");
    endtask

    task automatic compare_falls(input string tag);
        chk(obs0.size(), exp0.size(), {tag, "_t0_fall_count"});
        chk(obs1.size(), exp1.size(), {tag, "_t1_fall_count"});
        for (int i = 0; i < exp0.size() && i < obs0.size(); i++)
            chk(obs0[i], exp0[i], $sformatf("%s_t0_fall%0d", tag, i));
        for (int i = 0; i < exp1.size() && i < obs1.size(); i++)
            chk(obs1[i], exp1[i], $sformatf("%s_t1_fall%0d", tag, i));
        obs0.delete(); exp0.delete(); obs1.delete(); exp1.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({t0_clk_out, t0_data_out, t0_sel_out, t0_le_out}, 0, {tag, "_t0_strobes"});
        chk({t1_clk_out, t1_data_out, t1_sel_out, t1_le_out}, 0, {tag, "_t1_strobes"});
        chk(t0_mdi, 0, {tag, "_t0_mdi"});
        chk(t1_mdi, 0, {tag, "_t1_mdi"});
    endtask

    initial begin
        logic [7:0] pat;
        logic [15:0] pat16;
        logic [7:0] r;
        int op;

        // Power-on reset.
        #2 reset = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        repeat (3) tick();
        check_all_zero("post_reset_idle");

        // Shift 8'hC3 MSB-first and latch with latency checks.
        pat = 8'hC3;
        shift_byte(pat);
        idle();
        latch_pulse(1'b1);
        chk(t0_mdi, pat, "shift_latch_C3");
        compare_falls("shift_C3");

        // Capture 8'h5A then shift it out.
        t0_mdo = 8'h5A;
        t1_mdo = 8'($urandom);
        idle();
        scan_clock(1'b0, 1'b1, 1, 1);
        r = 8'($urandom);
        shift_byte(r);
        idle();
        pat = 8'h5A;
        for (int i = 0; i < 8; i++)
            chk((i < obs0.size()) ? obs0[i] : 1'bx, pat[7-i], $sformatf("capture_5A_bit%0d", i));
        compare_falls("capture_5A");
        latch_pulse(1'b0);
        chk(t0_mdi, r, "capture_then_shift_latch");

        // Two-tile chain: tile1's 0x0F emerges first, then tile0's 0xF0.
        t0_mdo = 8'hF0;
        t1_mdo = 8'h0F;
        idle();
        scan_clock(1'b0, 1'b1, 1, 1);
        shift_byte(8'($urandom));
        shift_byte(8'($urandom));
        idle();
        pat16 = 16'h0FF0;
        for (int i = 0; i < 16; i++)
            chk((i < obs1.size()) ? obs1[i] : 1'bx, pat16[15-i], $sformatf("chain_bit%0d", i));
        compare_falls("chain");
        latch_pulse(1'b0);

        // Latch enable and scan clock rising together: latch takes the pre-shift byte.
        pat = 8'h81;
        shift_byte(pat);
        idle();
        scan_data_in = 1'b1;
        scan_select_in = 1'b0;
        scan_clk_in = 1'b0;
        tick();
        scan_clk_in = 1'b1;
        scan_latch_en_in = 1'b1;
        mdi0 = m0;
        mdi1 = m1;
        model_clock(1'b1, 1'b0);
        for (int k = 1; k <= S + 1; k++) begin
            tick();
            if (k == S) chk(t0_clk_out, 0, "clk_out_before_latency");
            if (k == S + 1) begin
                chk(t0_clk_out, 1, "clk_out_at_latency");
                chk(t0_le_out, 1, "simul_le_out");
                chk(t0_mdi, pat, "simul_latch_pre_shift");
            end
        end
        scan_clk_in = 1'b0;
        scan_latch_en_in = 1'b0;
        idle();
        chk(t0_mdi, pat, "simul_latch_hold");
        chk(t1_mdi, mdi1, "simul_t1_mdi");
        compare_falls("simul");

        // Randomized shifts, captures and latches with 1..3 clk phase widths.
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 7));
            if (op <= 4) begin
                scan_clock(1'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(1, 3)),
                           int'($urandom_range(1, 3)));
            end else if (op == 5) begin
                latch_pulse(1'b0);
            end else begin
                idle();
                t0_mdo = 8'($urandom);
                t1_mdo = 8'($urandom);
            end
        end
        idle();
        compare_falls("random");
        latch_pulse(1'b0);

        // Asynchronous reset mid-shift after 8'hA5 has been latched.
        pat = 8'hA5;
        shift_byte(pat);
        idle();
        latch_pulse(1'b0);
        chk(t0_mdi, pat, "pre_reset_latch_A5");
        compare_falls("pre_reset");
        for (int i = 0; i < 3; i++) scan_clock(1'($urandom), 1'b0, 1, 1);
        scan_clk_in = 1'b1;
        scan_data_in = 1'b1;
        tick();
        reset = 1'b1;
        #2;
        check_all_zero("async_reset");
        prev_ck0 = 1'b0; prev_do0 = 1'b0; prev_ck1 = 1'b0; prev_do1 = 1'b0;
        scan_clk_in = 1'b0;
        scan_data_in = 1'b0;
        scan_select_in = 1'b0;
        scan_latch_en_in = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        m0 = 8'h00; m1 = 8'h00; mdi0 = 8'h00; mdi1 = 8'h00;
        obs0.delete(); exp0.delete(); obs1.delete(); exp1.delete();
        idle();
        check_all_zero("reset_release_idle");
        latch_pulse(1'b0);
        chk(t0_mdi, 0, "latch_after_reset_zero");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
